hdmi_circle_overlay: RTL and testbench

- Parametrised successor to the fixed single-disc HDMI overlay.
- Derives pixel coordinates from the incoming de/hs/vs timing.
- Draws a run-time configurable circle (filled disc, ring, or outside mask) at any centre and radius, through a 3-stage pipelined distance compare.
- Sits inline on the HDMI video path between the source pipeline and the TMDS encoder; all timing signals are delayed to stay aligned with the modified pixel data.

---
 rtl/hdmi_circle_overlay.sv | 211 +++++++++++++++++++++
 tb/tb_hdmi_circle_overlay.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hdmi_circle_overlay.sv
// Inline HDMI overlay: derives pixel coordinates from de/hs/vs and draws a
// configurable disc, ring or outside mask through a 3-stage distance compare.
module hdmi_circle_overlay #(
    parameter int unsigned COORD_W = 11,
    parameter int unsigned COLOR_W = 8,
    parameter bit          VS_POL  = 1'b1,
    parameter int unsigned LATENCY = 3
) (
    input  logic                   hdmi_clk,
    input  logic                   hdmi_rst_n,
    input  logic                   hdmi_de,
    input  logic                   hdmi_hs,
    input  logic                   hdmi_vs,
    input  logic [COLOR_W-1:0]     hdmi_r,
    input  logic [COLOR_W-1:0]     hdmi_g,
    input  logic [COLOR_W-1:0]     hdmi_b,
    input  logic [COORD_W-1:0]     cfg_cx,
    input  logic [COORD_W-1:0]     cfg_cy,
    input  logic [COORD_W-1:0]     cfg_radius,
    input  logic [COORD_W-1:0]     cfg_thick,
    input  logic [1:0]             cfg_mode,
    input  logic [3*COLOR_W-1:0]   cfg_color,
    output logic                   hdmi_de_out,
    output logic                   hdmi_hs_out,
    output logic                   hdmi_vs_out,
    output logic [3*COLOR_W-1:0]   hdmi_data_out,
    output logic                   cfg_applied
);

    localparam int unsigned DW  = COORD_W + 1;
    localparam int unsigned SW  = 2 * COORD_W + 2;
    localparam int unsigned D2W = 2 * COORD_W + 3;
    localparam int unsigned RW  = 2 * COORD_W;
    localparam int unsigned PW  = 3 * COLOR_W;
    localparam int unsigned S2  = 1;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_DISC = 2'd1,
        MODE_RING = 2'd2,
        MODE_MASK = 2'd3
    } mode_t;

    logic [PW-1:0]      pix_in;
    logic               vs_act;
    logic               vs_act_q;
    logic               vs_edge;
    logic               de_q;
    logic [COORD_W-1:0] x_cnt;
    logic [COORD_W-1:0] y_cnt;
    logic [COORD_W-1:0] x_cur;

    logic [COORD_W-1:0] sh_cx;
    logic [COORD_W-1:0] sh_cy;
    logic [COORD_W-1:0] sh_radius;
    logic [COORD_W-1:0] sh_thick;
    mode_t              sh_mode;
    logic [PW-1:0]      sh_color;
    logic [COORD_W-1:0] inner_r;
    logic [RW-1:0]      r_ext;
    logic [RW-1:0]      i_ext;
    logic [RW-1:0]      rsq;
    logic [RW-1:0]      isq;

    logic [DW-1:0]      dx_q;
    logic [DW-1:0]      dy_q;
    logic [PW-1:0]      pix1_q;
    logic [DW-1:0]      adx;
    logic [DW-1:0]      ady;
    logic [SW-1:0]      dx2;
    logic [SW-1:0]      dy2;
    logic [SW-1:0]      dx2_q;
    logic [SW-1:0]      dy2_q;
    logic [PW-1:0]      pix2_q;
    logic [D2W-1:0]     d2;
    logic               in_outer;
    logic               in_inner;
    logic [PW-1:0]      pix_sel;
    logic [2:0]         sync_q [LATENCY];

    assign pix_in  = {hdmi_r, hdmi_g, hdmi_b};
    assign vs_act  = (hdmi_vs == VS_POL);
    assign vs_edge = vs_act && !vs_act_q;
    assign x_cur   = hdmi_de ? x_cnt : '0;

    // vs_act_q resets to "active" so a sync already asserted at release is not a new edge
    always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n) begin
            vs_act_q <= 1'b1;
            de_q     <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
        end else begin
            vs_act_q <= vs_act;
            de_q     <= hdmi_de;
            if (hdmi_de) begin
                if (x_cnt != '1)
                    x_cnt <= x_cnt + 1'b1;
            end else begin
                x_cnt <= '0;
            end
            if (vs_edge)
                y_cnt <= '0;
            else if (de_q && !hdmi_de && y_cnt != '1)
                y_cnt <= y_cnt + 1'b1;
        end
    end

    assign inner_r = sh_radius - sh_thick;
    assign r_ext   = {{COORD_W{1'b0}}, sh_radius};
    assign i_ext   = {{COORD_W{1'b0}}, inner_r};

    // Squares are refreshed the cycle after capture, well before active video resumes
    always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n) begin
            cfg_applied <= 1'b0;
            sh_cx       <= '0;
            sh_cy       <= '0;
            sh_radius   <= '0;
            sh_thick    <= '0;
            sh_mode     <= MODE_PASS;
            sh_color    <= '0;
            rsq         <= '0;
            isq         <= '0;
        end else begin
            cfg_applied <= vs_edge;
            if (vs_edge) begin
                sh_cx     <= cfg_cx;
                sh_cy     <= cfg_cy;
                sh_radius <= cfg_radius;
                sh_thick  <= cfg_thick;
                sh_mode   <= mode_t'(cfg_mode);
                sh_color  <= cfg_color;
            end
            if (cfg_applied) begin
                rsq <= r_ext * r_ext;
                isq <= (sh_thick >= sh_radius) ? '0 : i_ext * i_ext;
            end
        end
    end

    always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++)
                sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {hdmi_de, hdmi_hs, hdmi_vs};
            for (int unsigned i = 1; i < LATENCY; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n) begin
            dx_q   <= '0;
            dy_q   <= '0;
            pix1_q <= '0;
        end else begin
            dx_q   <= {1'b0, x_cur} - {1'b0, sh_cx};
            dy_q   <= {1'b0, y_cnt} - {1'b0, sh_cy};
            pix1_q <= pix_in;
        end
    end

    // Square the magnitude; the sign is irrelevant to the distance
    always_comb begin
        adx = dx_q[DW-1] ? (~dx_q + 1'b1) : dx_q;
        ady = dy_q[DW-1] ? (~dy_q + 1'b1) : dy_q;
        dx2 = {{DW{1'b0}}, adx} * {{DW{1'b0}}, adx};
        dy2 = {{DW{1'b0}}, ady} * {{DW{1'b0}}, ady};
    end

    always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n) begin
            dx2_q  <= '0;
            dy2_q  <= '0;
            pix2_q <= '0;
        end else begin
            dx2_q  <= dx2;
            dy2_q  <= dy2;
            pix2_q <= pix1_q;
        end
    end

    always_comb begin
        d2       = {1'b0, dx2_q} + {1'b0, dy2_q};
        in_outer = d2 <= {3'b000, rsq};
        in_inner = d2 <  {3'b000, isq};
        pix_sel  = pix2_q;
        if (sync_q[S2][2]) begin
            case (sh_mode)
                MODE_DISC: if (in_outer) pix_sel = sh_color;
                MODE_RING: if (in_outer && !in_inner) pix_sel = sh_color;
                MODE_MASK: if (!in_outer) pix_sel = '0;
                default:   pix_sel = pix2_q;
            endcase
        end
    end

    always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n)
            hdmi_data_out <= '0;
        else
            hdmi_data_out <= pix_sel;
    end

    assign hdmi_de_out = sync_q[LATENCY-1][2];
    assign hdmi_hs_out = sync_q[LATENCY-1][1];
    assign hdmi_vs_out = sync_q[LATENCY-1][0];

endmodule

// File: tb/tb_hdmi_circle_overlay.sv
// Bench for hdmi_circle_overlay: frames of random pixels, a coordinate-level
// reference model and a per-cycle compare of every output.
module tb_hdmi_circle_overlay;

    localparam int W      = 11;
    localparam int XMAX   = 2047;
    localparam bit VS_POL = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        de, hs, vs;
    logic [7:0]  r, g, b;
    logic [10:0] cfg_cx, cfg_cy, cfg_radius, cfg_thick;
    logic [1:0]  cfg_mode;
    logic [23:0] cfg_color;
    logic        de_out, hs_out, vs_out, applied;
    logic [23:0] data_out;

    int total = 0;
    int bad   = 0;

    logic [26:0] mp [3];
    logic        app_exp;
    logic        prev_act;
    int          m_mode, m_cx, m_cy, m_r, m_t;
    logic [23:0] m_col;

    hdmi_circle_overlay #(.COORD_W(W), .COLOR_W(8), .VS_POL(VS_POL), .LATENCY(3)) dut (
        .hdmi_clk(clk), .hdmi_rst_n(rst_n),
        .hdmi_de(de), .hdmi_hs(hs), .hdmi_vs(vs),
        .hdmi_r(r), .hdmi_g(g), .hdmi_b(b),
        .cfg_cx(cfg_cx), .cfg_cy(cfg_cy), .cfg_radius(cfg_radius), .cfg_thick(cfg_thick),
        .cfg_mode(cfg_mode), .cfg_color(cfg_color),
        .hdmi_de_out(de_out), .hdmi_hs_out(hs_out), .hdmi_vs_out(vs_out),
        .hdmi_data_out(data_out), .cfg_applied(applied)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] model_pixel(input int x, input int y, input logic [23:0] pix,
                                                input int mode, input int cx, input int cy,
                                                input int rad, input int thk, input logic [23:0] col);
        longint dxl, dyl, d2;
        bit outer, inner;
        dxl   = longint'(x - cx);
        dyl   = longint'(y - cy);
        d2    = dxl * dxl + dyl * dyl;
        outer = d2 <= longint'(rad) * longint'(rad);
        inner = (thk < rad) && (d2 < longint'(rad - thk) * longint'(rad - thk));
        case (mode)
            1:       return outer ? col : pix;
            2:       return (outer && !inner) ? col : pix;
            3:       return outer ? pix : 24'h0;
            default: return pix;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        total++;
        if ({de_out, hs_out, vs_out, data_out} !== mp[2]) begin
            bad++;
            $display("FAIL video got=%h want=%h t=%0t", {de_out, hs_out, vs_out, data_out}, mp[2], $time);
        end
        total++;
        if (applied !== app_exp) begin
            bad++;
            $display("FAIL cfg_applied got=%b want=%b t=%0t", applied, app_exp, $time);
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 3; i++) mp[i] = '0;
        app_exp  = 1'b0;
        prev_act = 1'b1;
        m_mode = 0; m_cx = 0; m_cy = 0; m_r = 0; m_t = 0; m_col = '0;
    endtask

    // One pixel-clock cycle of stimulus; px/py are the coordinates this pixel must carry
    task automatic drive(input logic d, input logic h, input logic v, input int px, input int py);
        logic [23:0] pix;
        logic [26:0] item;
        logic        edge_v;
        pix = 24'($urandom);
        de = d; hs = h; vs = v;
        {r, g, b} = pix;
        edge_v = rst_n && (v == VS_POL) && !prev_act;
        if (!rst_n)
            item = '0;
        else
            item = {d, h, v, d ? model_pixel(px, py, pix, m_mode, m_cx, m_cy, m_r, m_t, m_col) : pix};
        @(posedge clk);
        mp[2] = mp[1];
        mp[1] = mp[0];
        mp[0] = item;
        app_exp  = edge_v;
        prev_act = rst_n ? (v == VS_POL) : 1'b1;
        if (edge_v) begin
            m_mode = int'(cfg_mode);
            m_cx = int'(cfg_cx); m_cy = int'(cfg_cy);
            m_r  = int'(cfg_radius); m_t = int'(cfg_thick);
            m_col = cfg_color;
        end
        #1;
    endtask

    task automatic reset_pulse();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async", {5'b0, de_out, hs_out, vs_out, data_out}, 32'h0);
        check("rst_applied", {31'b0, applied}, 32'h0);
        model_clear();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic frame(input int w, input int h, input int chg_l, input int chg_r,
                         input int rst_l, input int rst_p);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, VS_POL, 0, 0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, ~VS_POL, 0, 0);
        for (int l = 0; l < h; l++) begin
            if (l == chg_l) cfg_radius = 11'(chg_r);
            for (int p = 0; p < w; p++) begin
                if (l == rst_l && p == rst_p) reset_pulse();
                drive(1'b1, 1'b0, ~VS_POL, (p > XMAX) ? XMAX : p, l);
            end
            for (int i = 0; i < 6; i++) drive(1'b0, (i >= 1 && i < 4), ~VS_POL, 0, 0);
        end
    endtask

    task automatic set_cfg(input int mode, input int cx, input int cy, input int rad,
                           input int thk, input logic [23:0] col);
        cfg_mode = 2'(mode); cfg_cx = 11'(cx); cfg_cy = 11'(cy);
        cfg_radius = 11'(rad); cfg_thick = 11'(thk); cfg_color = col;
    endtask

    initial begin
        logic [23:0] p0;
        logic [23:0] red;
        p0  = 24'h123456;
        red = 24'hFF0000;
        rst_n = 1'b0;
        de = 1'b0; hs = 1'b0; vs = ~VS_POL; r = '0; g = '0; b = '0;
        set_cfg(0, 0, 0, 0, 0, '0);
        model_clear();

        check("pin_m1_42_32", model_pixel(42, 32, p0, 1, 32, 32, 10, 0, red), red);
        check("pin_m1_43_32", model_pixel(43, 32, p0, 1, 32, 32, 10, 0, red), p0);
        check("pin_m1_40_38", model_pixel(40, 38, p0, 1, 32, 32, 10, 0, red), red);
        check("pin_m1_41_39", model_pixel(41, 39, p0, 1, 32, 32, 10, 0, red), p0);
        check("pin_m2_42_32", model_pixel(42, 32, p0, 2, 32, 32, 10, 3, red), red);
        check("pin_m2_38_32", model_pixel(38, 32, p0, 2, 32, 32, 10, 3, red), p0);
        check("pin_m2_39_32", model_pixel(39, 32, p0, 2, 32, 32, 10, 3, red), red);
        check("pin_m2_thick", model_pixel(32, 32, p0, 2, 32, 32, 10, 12, red), red);
        check("pin_m3_5_0",   model_pixel(5, 0, p0, 3, 0, 0, 5, 0, red), p0);
        check("pin_m3_6_0",   model_pixel(6, 0, p0, 3, 0, 0, 5, 0, red), 24'h0);
        check("pin_m3_4_4",   model_pixel(4, 4, p0, 3, 0, 0, 5, 0, red), 24'h0);
        check("pin_r0_in",    model_pixel(5, 3, p0, 1, 5, 3, 0, 0, red), red);
        check("pin_r0_out",   model_pixel(6, 3, p0, 1, 5, 3, 0, 0, red), p0);

        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, ~VS_POL, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        set_cfg(0, 0, 0, 0, 0, red);     frame(64, 64, -1, 0, -1, 0);
        set_cfg(1, 32, 32, 10, 0, red);  frame(64, 64, -1, 0, -1, 0);
        set_cfg(2, 32, 32, 10, 3, red);  frame(64, 64, -1, 0, -1, 0);
        set_cfg(2, 32, 32, 10, 12, red); frame(64, 48, -1, 0, -1, 0);
        set_cfg(3, 0, 0, 5, 0, red);     frame(16, 8, -1, 0, -1, 0);
        set_cfg(1, 5, 3, 0, 0, 24'h00FF00); frame(12, 8, -1, 0, -1, 0);
        set_cfg(1, 32, 32, 10, 0, red);  frame(64, 64, 20, 20, -1, 0);
        frame(64, 64, -1, 0, -1, 0);
        set_cfg(1, 8, 8, 6, 0, 24'h0000FF); frame(20, 16, -1, 0, 5, 10);
        frame(20, 16, -1, 0, -1, 0);
        set_cfg(1, 2040, 0, 10, 0, red); frame(2100, 2, -1, 0, -1, 0);
        for (int k = 0; k < 3; k++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 80), $urandom_range(0, 70),
                    $urandom_range(0, 40), $urandom_range(0, 40), 24'($urandom));
            frame(48, 40, -1, 0, -1, 0);
        end
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, ~VS_POL, 0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
